// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB master.
package sccb_pkg;
    typedef enum logic [2:0] {IDLE, START_A, START_B, BIT, STOP_A, STOP_B, STOP_C, GAP} state_t;
    localparam logic SCCB_WRITE = 1'b0;
    localparam logic SCCB_READ = 1'b1;
    localparam logic [7:0] OV7670_WRITE_ID = 8'h42;
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;
endpackage

// File: rtl/sccb_tick_gen.sv
// sccb_tick_gen: prescaler producing one tick every CLK_DIV clocks (one SIOC quarter-period).
// Ports: clk, rst_n (async active-low), clr (restart count from 0), tick (high on count CLK_DIV-1).
module sccb_tick_gen
    import sccb_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick = cnt_q == W'(CLK_DIV - 1);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/sccb_master.sv
// sccb_master: SCCB/I2C register master with valid/ready commands, reads, ACK checking.
// Ports: cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_wdata command channel; rsp_valid/rsp_rdata/rsp_nack
// completion pulse; busy; sioc and siod_o/siod_oe/siod_i pad signals.
module sccb_master
    import sccb_pkg::*;
#(
    parameter int CLK_DIV = 125,
    parameter logic [7:0] DEV_ID = OV7670_WRITE_ID,
    parameter int BUS_FREE = 4,
    parameter bit CHECK_ACK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       sioc,
    output logic       siod_o,
    output logic       siod_oe,
    input  logic       siod_i
);
    localparam int GW = $clog2(BUS_FREE + 1);
    state_t state_q, state_d;
    logic [1:0] qtr_q, qtr_d, byte_q, byte_d;
    logic [3:0] pos_q, pos_d;
    logic [GW-1:0] gap_q, gap_d;
    logic phase2_q, phase2_d, rw_q, rw_d, nack_q, nack_d, rsp_valid_q, rsp_valid_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, tx_byte;
    logic sioc_q, sioc_d, siod_o_q, siod_o_d, siod_oe_q, siod_oe_d;
    logic tick, accept, rx_q, rx_d;
    sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .clr(accept), .tick(tick));
    assign cmd_ready = state_q == IDLE;
    assign busy = !cmd_ready;
    assign accept = cmd_valid && cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack = nack_q;
    assign sioc = sioc_q;
    assign siod_o = siod_o_q;
    assign siod_oe = siod_oe_q;
    always_comb begin
        state_d = state_q;
        qtr_d = qtr_q;
        byte_d = byte_q;
        pos_d = pos_q;
        gap_d = gap_q;
        phase2_d = phase2_q;
        rw_d = rw_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        nack_d = nack_q;
        rsp_valid_d = 1'b0;
        // second byte of the read phase is slave-driven data
        rx_q = phase2_q && byte_q == 2'd1;
        if (accept) begin
            state_d = START_A;
            rw_d = cmd_rw;
            addr_d = cmd_addr;
            wdata_d = cmd_wdata;
            rdata_d = '0;
            nack_d = 1'b0;
            phase2_d = 1'b0;
        end else if (tick) begin
            case (state_q)
                START_A: state_d = START_B;
                START_B: begin
                    state_d = BIT;
                    qtr_d = Q0;
                    byte_d = '0;
                    pos_d = '0;
                end
                BIT: begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == Q2 && rx_q && !pos_q[3]) rdata_d = {rdata_q[6:0], siod_i};
                    if (qtr_q == Q2 && !rx_q && pos_q[3]) nack_d = nack_q | (CHECK_ACK & siod_i);
                    if (qtr_q == Q3) begin
                        pos_d = pos_q[3] ? 4'd0 : pos_q + 4'd1;
                        byte_d = pos_q[3] ? byte_q + 2'd1 : byte_q;
                        if (pos_q[3] && byte_q == (rw_q == SCCB_READ ? 2'd1 : 2'd2)) state_d = STOP_A;
                    end
                end
                STOP_A: state_d = STOP_B;
                STOP_B: state_d = STOP_C;
                STOP_C: begin
                    state_d = GAP;
                    gap_d = '0;
                end
                GAP: begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GW'(BUS_FREE - 1)) begin
                        phase2_d = rw_q == SCCB_READ && !phase2_q;
                        state_d = phase2_d ? START_A : IDLE;
                        rsp_valid_d = !phase2_d;
                    end
                end
                default: ;
            endcase
        end
        // pad values follow the next state so they change on the same edge as the FSM
        rx_d = phase2_d && byte_d == 2'd1;
        tx_byte = byte_d == 2'd0 ? {DEV_ID[7:1], phase2_d} : byte_d == 2'd1 ? addr_q : wdata_q;
        sioc_d = state_d == BIT ? qtr_d[1] : state_d != STOP_A;
        siod_oe_d = state_d == BIT ? (pos_d[3] == rx_d) : !(state_d inside {IDLE, GAP});
        siod_o_d = state_d == BIT ? (pos_d[3] | tx_byte[~pos_d[2:0]]) : state_d inside {IDLE, START_A, STOP_C, GAP};
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            qtr_q <= Q0;
            byte_q <= '0;
            pos_q <= '0;
            gap_q <= '0;
            phase2_q <= 1'b0;
            rw_q <= SCCB_WRITE;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            nack_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            sioc_q <= 1'b1;
            siod_o_q <= 1'b1;
            siod_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            qtr_q <= qtr_d;
            byte_q <= byte_d;
            pos_q <= pos_d;
            gap_q <= gap_d;
            phase2_q <= phase2_d;
            rw_q <= rw_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            nack_q <= nack_d;
            rsp_valid_q <= rsp_valid_d;
            sioc_q <= sioc_d;
            siod_o_q <= siod_o_d;
            siod_oe_q <= siod_oe_d;
        end
endmodule
